// File: rtl/eth_tx_arb.sv
// N-channel GMII transmit arbiter: latches send requests, grants round-robin,
// muxes the granted generator onto the MAC byte interface with IFG and length limits.
module eth_tx_arb #(
  parameter int         N_CH          = 2,
  parameter int         IFG_CYCLES    = 12,
  parameter int         MAX_LEN       = 1526,
  parameter int         START_TIMEOUT = 64,
  parameter logic [7:0] CMD_BASE      = 8'd64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_cmd_addr,
  input  logic [31:0]           i_cmd_data,
  input  logic                  i_cmd_wr,
  input  logic [N_CH-1:0]       i_req,
  output logic [N_CH-1:0]       o_start,
  input  logic [8*N_CH-1:0]     i_ch_data,
  input  logic [N_CH-1:0]       i_ch_en,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_en,
  output logic                  o_busy,
  output logic                  o_irq_tx,
  output logic [2:0]            o_last_ch,
  output logic [15:0]           o_last_len,
  output logic [15:0]           o_frame_cnt,
  output logic [2*N_CH-1:0]     o_err
);

  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WAIT_W = $clog2(START_TIMEOUT + 1);
  localparam int IFG_W  = $clog2(IFG_CYCLES + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_TIMEOUT - 1);
  localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'(IFG_CYCLES - 1);
  localparam logic [15:0]       LEN_MAX   = 16'(MAX_LEN);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EN,
    S_SEND,
    S_DRAIN,
    S_IFG
  } state_t;

  state_t              state;
  logic [N_CH-1:0]     pending;
  logic [N_CH-1:0]     mask;
  logic [CH_W-1:0]     rr;
  logic [CH_W-1:0]     cur;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [15:0]         len_cnt;
  logic [IFG_W-1:0]    ifg_cnt;

  logic [7:0]          ch_bytes [N_CH];
  logic [N_CH-1:0]     eligible;
  logic                gnt_ok;
  logic [CH_W-1:0]     gnt;
  logic                hi_ok;
  logic                lo_ok;
  logic [CH_W-1:0]     hi_idx;
  logic [CH_W-1:0]     lo_idx;
  logic [N_CH-1:0]     gnt_oh;
  logic [N_CH-1:0]     cur_oh;
  logic                grant_fire;
  logic [N_CH-1:0]     grant_clr;
  logic                cur_en;
  logic                pass;
  logic                timeout;
  logic                trunc;
  logic                wr_pend;
  logic                wr_mask;
  logic                wr_clr;
  logic [N_CH-1:0]     sw_set;
  logic [2*N_CH-1:0]   err_clr;
  logic [2*N_CH-1:0]   err_set;
  logic                unused_cmd;

  for (genvar k = 0; k < N_CH; k++) begin : g_bytes
    assign ch_bytes[k] = i_ch_data[8*k +: 8];
  end

  assign wr_pend = i_cmd_wr && (i_cmd_addr == CMD_BASE);
  assign wr_mask = i_cmd_wr && (i_cmd_addr == CMD_BASE + 8'd4);
  assign wr_clr  = i_cmd_wr && (i_cmd_addr == CMD_BASE + 8'd8);
  assign sw_set  = wr_pend ? i_cmd_data[N_CH-1:0] : '0;
  assign err_clr = wr_clr ? i_cmd_data[2*N_CH-1:0] : '0;
  assign unused_cmd = ^i_cmd_data[31:2*N_CH];

  assign eligible = pending & mask;

  // Round-robin: lowest eligible index at or above rr wins, else lowest overall.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    hi_ok  = 1'b0;
    lo_ok  = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        lo_ok  = 1'b1;
        lo_idx = CH_W'(k);
        if (CH_W'(k) >= rr) begin
          hi_ok  = 1'b1;
          hi_idx = CH_W'(k);
        end
      end
    end
    gnt_ok = lo_ok;
    gnt    = hi_ok ? hi_idx : lo_idx;
  end

  assign gnt_oh     = N_CH'(1) << gnt;
  assign cur_oh     = N_CH'(1) << cur;
  assign grant_fire = (state == S_IDLE) && gnt_ok;
  assign grant_clr  = grant_fire ? gnt_oh : '0;
  assign cur_en     = i_ch_en[cur];

  assign timeout = (state == S_WAIT_EN) && !cur_en && (wait_cnt == WAIT_LAST);
  assign trunc   = (state == S_SEND) && cur_en && (len_cnt == LEN_MAX);
  assign err_set = {cur_oh & {N_CH{trunc}}, cur_oh & {N_CH{timeout}}};

  // Zero-latency pass-through; the first enabled byte arrives while still in WAIT_EN.
  assign pass      = cur_en && ((state == S_WAIT_EN) ||
                                ((state == S_SEND) && (len_cnt != LEN_MAX)));
  assign o_tx_en   = pass;
  assign o_tx_data = pass ? ch_bytes[cur] : 8'h00;
  assign o_busy    = (state != S_IDLE);

  // NOTE: all state below uses non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pending     <= '0;
      mask        <= '1;
      rr          <= '0;
      cur         <= '0;
      wait_cnt    <= '0;
      len_cnt     <= '0;
      ifg_cnt     <= '0;
      o_start     <= '0;
      o_irq_tx    <= 1'b0;
      o_last_ch   <= '0;
      o_last_len  <= '0;
      o_frame_cnt <= '0;
      o_err       <= '0;
    end else begin
      o_start  <= '0;
      o_irq_tx <= 1'b0;
      pending  <= (pending & ~grant_clr) | i_req | sw_set;
      o_err    <= (o_err & ~err_clr) | err_set;
      if (wr_mask) mask <= i_cmd_data[N_CH-1:0];

      case (state)
        S_IDLE: begin
          if (gnt_ok) begin
            cur      <= gnt;
            rr       <= (gnt == CH_LAST) ? '0 : gnt + 1'b1;
            o_start  <= gnt_oh;
            wait_cnt <= '0;
            state    <= S_WAIT_EN;
          end
        end
        S_WAIT_EN: begin
          if (cur_en) begin
            len_cnt <= 16'd1;
            state   <= S_SEND;
          end else if (timeout) begin
            ifg_cnt <= '0;
            state   <= S_IFG;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SEND: begin
          if (!cur_en) begin
            o_last_len  <= len_cnt;
            o_last_ch   <= 3'(cur);
            o_irq_tx    <= 1'b1;
            o_frame_cnt <= o_frame_cnt + 16'd1;
            ifg_cnt     <= '0;
            state       <= S_IFG;
          end else if (trunc) begin
            o_last_len  <= LEN_MAX;
            o_last_ch   <= 3'(cur);
            o_irq_tx    <= 1'b1;
            o_frame_cnt <= o_frame_cnt + 16'd1;
            state       <= S_DRAIN;
          end else begin
            len_cnt <= len_cnt + 16'd1;
          end
        end
        S_DRAIN: begin
          if (!cur_en) begin
            ifg_cnt <= '0;
            state   <= S_IFG;
          end
        end
        S_IFG: begin
          if (ifg_cnt == IFG_LAST) state <= S_IDLE;
          else                     ifg_cnt <= ifg_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Randomized bench for eth_tx_arb: a frame-level model tracks pending requests,
// the round-robin order, counters and sticky errors, and is compared at every frame.
module tb_eth_tx_arb;

  localparam int         N_CH = 2;
  localparam int         IFG  = 12;
  localparam int         MAXL = 1526;
  localparam int         TO   = 64;
  localparam logic [7:0] BASE = 8'd64;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          cmd_addr;
  logic [31:0]         cmd_data;
  logic                cmd_wr;
  logic [N_CH-1:0]     req;
  logic [N_CH-1:0]     start;
  logic [8*N_CH-1:0]   ch_data;
  logic [N_CH-1:0]     ch_en;
  logic [7:0]          tx_data;
  logic                tx_en;
  logic                busy;
  logic                irq;
  logic [2:0]          last_ch;
  logic [15:0]         last_len;
  logic [15:0]         frame_cnt;
  logic [2*N_CH-1:0]   err;

  eth_tx_arb #(
    .N_CH(N_CH), .IFG_CYCLES(IFG), .MAX_LEN(MAXL), .START_TIMEOUT(TO), .CMD_BASE(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_cmd_wr(cmd_wr),
    .i_req(req), .o_start(start),
    .i_ch_data(ch_data), .i_ch_en(ch_en),
    .o_tx_data(tx_data), .o_tx_en(tx_en), .o_busy(busy), .o_irq_tx(irq),
    .o_last_ch(last_ch), .o_last_len(last_len), .o_frame_cnt(frame_cnt), .o_err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int irq_seen = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (irq === 1'b1) irq_seen++;

  int checks = 0;
  int failures = 0;

  // Frame-level reference model
  logic [N_CH-1:0]   m_pend;
  logic [N_CH-1:0]   m_mask;
  int                m_rr;
  logic [2*N_CH-1:0] m_err;
  logic [15:0]       m_frames;
  int                last_end;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_has_work();
    return |(m_pend & m_mask);
  endfunction

  function automatic int model_grant();
    for (int i = 0; i < N_CH; i++) begin
      int c;
      c = (m_rr + i) % N_CH;
      if (m_pend[c] && m_mask[c]) begin
        m_pend[c] = 1'b0;
        m_rr = (c + 1) % N_CH;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '1; m_rr = 0; m_err = '0; m_frames = '0; last_end = -1;
  endtask

  task automatic hw_req(input logic [N_CH-1:0] bits);
    req = bits;
    nxt();
    req = '0;
    m_pend |= bits;
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [31:0] d);
    cmd_addr = a; cmd_data = d; cmd_wr = 1'b1;
    nxt();
    cmd_wr = 1'b0;
    if (a == BASE)              m_pend |= d[N_CH-1:0];
    else if (a == BASE + 8'd4)  m_mask = d[N_CH-1:0];
    else if (a == BASE + 8'd8)  m_err &= ~d[2*N_CH-1:0];
  endtask

  task automatic wait_start(input int exp);
    bit seen;
    int gap;
    logic [N_CH-1:0] exp_oh;
    seen = 1'b0;
    exp_oh = '0;
    exp_oh[exp] = 1'b1;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      if (start != '0) begin
        seen = 1'b1;
        check("start_ch", start, exp_oh);
        if (last_end >= 0) begin
          gap = cyc - last_end;
          check("ifg_gap", (gap >= IFG + 1 && gap <= IFG + 4), 1);
        end
      end
      nxt();
    end
    check("start_seen", seen, 1);
  endtask

  task automatic expect_no_start(input int n);
    int s;
    s = 0;
    repeat (n) begin
      @(negedge clk);
      if (start != '0) s++;
      nxt();
    end
    check("no_start", s, 0);
  endtask

  task automatic do_frame(input int delay, input int len, input bit seq,
                          input logic [N_CH-1:0] mid_req);
    int exp, k, bad, en_cnt, exp_len;
    bit on, exp_en;
    logic [7:0] b;
    exp = model_grant();
    if (exp < 0) return;
    irq_seen = 0;
    wait_start(exp);
    bad = 0;
    en_cnt = 0;
    for (int i = 0; i < delay + len; i++) begin
      k  = i - (delay - 1);
      on = (k >= 0) && (k < len);
      b  = seq ? 8'(8'h55 + k) : 8'($urandom);
      ch_data = 16'($urandom);
      ch_data[8*exp +: 8] = b;
      ch_en = N_CH'($urandom);
      ch_en[exp] = on;
      req = (k == 2) ? mid_req : '0;
      @(negedge clk);
      if (i == 0) check("start_one_cycle", start, '0);
      exp_en = on && (k < MAXL);
      if (tx_en !== exp_en || tx_data !== (exp_en ? b : 8'h00) || busy !== 1'b1) bad++;
      if (tx_en === 1'b1) en_cnt++;
      if (k == len) last_end = cyc;
      nxt();
    end
    ch_en = '0;
    req = '0;
    repeat (2) nxt();
    exp_len = (len > MAXL) ? MAXL : len;
    m_pend |= mid_req;
    m_frames++;
    if (len > MAXL) m_err[N_CH + exp] = 1'b1;
    check("tx_stream", bad, 0);
    check("tx_en_cycles", en_cnt, exp_len);
    check("irq_count", irq_seen, 1);
    check("last_len", last_len, exp_len);
    check("last_ch", last_ch, exp);
    check("frame_cnt", frame_cnt, m_frames);
    check("err", err, m_err);
    if (!model_has_work()) last_end = -1;
  endtask

  task automatic do_timeout();
    int exp, bad;
    exp = model_grant();
    if (exp < 0) return;
    irq_seen = 0;
    wait_start(exp);
    bad = 0;
    for (int j = 1; j <= TO + 2; j++) begin
      ch_data = 16'($urandom);
      ch_en = N_CH'($urandom);
      ch_en[exp] = 1'b0;
      @(negedge clk);
      if (j == TO - 2) check("timeout_early", err[exp], 0);
      if (j == TO + 2) check("timeout_set", err[exp], 1);
      if (tx_en !== 1'b0 || tx_data !== 8'h00) bad++;
      nxt();
    end
    ch_en = '0;
    m_err[exp] = 1'b1;
    check("timeout_tx_quiet", bad, 0);
    check("timeout_no_irq", irq_seen, 0);
    check("timeout_frame_cnt", frame_cnt, m_frames);
    last_end = -1;
    cmd_write(BASE + 8'd8, 32'(1) << exp);
    @(negedge clk);
    check("err_w1c", err, m_err);
    nxt();
  endtask

  initial begin
    int exp;
    logic [N_CH-1:0] bits, mid;
    rst = 1'b1; cmd_addr = '0; cmd_data = '0; cmd_wr = 1'b0;
    req = '0; ch_en = '0; ch_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tx_en", tx_en, 0);
    check("rst_busy", busy, 0);
    check("rst_start", start, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err", err, 0);
    check("rst_last_len", last_len, 0);
    nxt();

    // Single frame, ch0, en 3 cycles after start, 72 bytes from 0x55
    hw_req(2'b01);
    do_frame(3, 72, 1'b1, '0);

    // Simultaneous requests, twice: pointer wraps back to ch0
    hw_req(2'b11);
    do_frame($urandom_range(1, 5), $urandom_range(8, 60), 1'b0, '0);
    do_frame($urandom_range(1, 5), $urandom_range(8, 60), 1'b0, '0);
    hw_req(2'b11);
    do_frame($urandom_range(1, 5), $urandom_range(8, 60), 1'b0, '0);
    do_frame($urandom_range(1, 5), $urandom_range(8, 60), 1'b0, '0);

    // Start timeout on ch1, then write-1-to-clear
    hw_req(2'b10);
    do_timeout();

    // Oversize frame on ch0; ch1 queued mid-frame so the gap after drain is measured
    hw_req(2'b01);
    do_frame(2, 2000, 1'b0, 2'b10);
    do_frame($urandom_range(1, 5), $urandom_range(8, 60), 1'b0, '0);

    // Masking: only ch1 eligible, ch0 retained until mask restored
    cmd_write(BASE + 8'd4, 32'h2);
    cmd_write(BASE, 32'h3);
    do_frame($urandom_range(1, 5), $urandom_range(8, 60), 1'b0, '0);
    expect_no_start(40);
    cmd_write(BASE + 8'd4, 32'h3);
    do_frame($urandom_range(1, 5), $urandom_range(8, 60), 1'b0, '0);

    // Random traffic, including requests arriving mid-frame
    for (int it = 0; it < 8; it++) begin
      bits = N_CH'($urandom_range(1, 3));
      hw_req(bits);
      for (int f = 0; f < 12 && model_has_work(); f++) begin
        mid = ($urandom_range(0, 3) == 0) ? N_CH'($urandom_range(1, 3)) : '0;
        do_frame($urandom_range(1, 6), $urandom_range(4, 90), 1'b0, mid);
      end
    end

    // Reset in the middle of a frame, with a request queued beforehand
    hw_req(2'b01);
    exp = model_grant();
    wait_start(exp);
    ch_data = 16'($urandom);
    ch_en = '0;
    ch_en[exp] = 1'b1;
    req = 2'b10;
    nxt();
    req = '0;
    nxt();
    @(negedge clk);
    check("pre_rst_tx_en", tx_en, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx_en", tx_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_err", err, 0);
    check("midrst_last_len", last_len, 0);
    ch_en = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    expect_no_start(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
